// File: rtl/pc_redirect_unit_pkg.sv
// Purpose : shared types and constants for the PC redirect unit slice.
// Latency : n/a (package only).
// Backpressure: n/a.
//
// Contents: pc_state_type FSM encoding, PC_STEP increment, RESET_PC_DEFAULT.
package pc_redirect_unit_pkg;

    // RUN accepts redirects; FLUSH drains wrong-path fetches and ignores execute.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } pc_state_type;

    // Sequential fetch advances one 32-bit instruction word.
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : pc_redirect_unit_pkg

// File: rtl/pc_redirect_unit_branch_stats_counter.sv
// Purpose : counts resolved and taken conditional branches (wrapping 32-bit counters).
// Latency : counters reflect an accepted branch one cycle after it resolves.
// Backpressure: none; the caller only asserts branch_accept_vld on accepted cycles.
//
// Ports:
//   clk, reset_n        - clock, async active-low reset
//   branch_accept_vld   - a conditional branch was accepted this cycle
//   branch_taken        - that branch was taken (qualified by branch_accept_vld)
//   branch_count        - number of accepted conditional branches
//   taken_count         - number of accepted taken branches
module branch_stats_counter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        branch_accept_vld,
    input  logic        branch_taken,
    output logic [31:0] branch_count,
    output logic [31:0] taken_count
);

    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] taken_count_q,  taken_count_d;

    always_comb begin
        branch_count_d = branch_count_q;
        taken_count_d  = taken_count_q;
        if (branch_accept_vld) begin
            branch_count_d = branch_count_q + 32'd1;
            if (branch_taken) begin
                taken_count_d = taken_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_count_q <= 32'd0;
            taken_count_q  <= 32'd0;
        end else begin
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    assign branch_count = branch_count_q;
    assign taken_count  = taken_count_q;

endmodule : branch_stats_counter

// File: rtl/pc_redirect_unit.sv
// Purpose : owns the fetch PC; turns taken branches/jumps into redirects plus a flush pulse.
// Latency : redirect resolved in cycle N -> pc = target and flush_o = 1 at N+1; all outputs registered.
// Backpressure: stall holds the PC (a redirect overrides it); execute inputs are ignored during FLUSH.
//
// Ports:
//   clk, reset_n                 - clock, async active-low reset
//   stall                        - hazard hold, PC does not advance
//   branch_valid/branch_result   - conditional branch resolving / taken
//   jump_valid                   - JAL/JALR resolving
//   target                       - redirect target from execute
//   pc                           - registered fetch address
//   flush_o                      - kill wrong-path instructions in IF/ID and ID/EX
//   misaligned_o                 - sticky: some redirect target had bit 1 set
//   branch_count/taken_count     - branch statistics
// Optional feature: PC_REDIRECT_STATS_EN enables the branch statistics counters;
// when undefined both count ports are tied to zero.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 2   // legal range 1..7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic        branch_result,
    input  logic        jump_valid,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic        flush_o,
    output logic        misaligned_o,
    output logic [31:0] branch_count,
    output logic [31:0] taken_count
);

    // Remaining FLUSH cycles after the current one; loaded so that flush_o
    // stays high for exactly FLUSH_CYCLES cycles.
    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    pc_state_type state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [2:0]   flush_cnt_q, flush_cnt_d;
    logic         flush_q, flush_d;
    logic         misaligned_q, misaligned_d;
    logic         redirect;

    // Redirects only count in RUN; during FLUSH the execute stage holds wrong-path work.
    assign redirect = (state_q == RUN) && ((branch_valid && branch_result) || jump_valid);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        flush_cnt_d  = flush_cnt_q;
        misaligned_d = misaligned_q;

        case (state_q)
            RUN: begin
                if (redirect) begin
                    // Bit 0 always cleared, matching JALR target formation.
                    pc_d        = target & ~32'h1;
                    flush_cnt_d = FLUSH_INIT;
                    state_d     = FLUSH;
                    if (target[1]) begin
                        misaligned_d = 1'b1;
                    end
                end else if (!stall) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    pc_d = pc_q + PC_STEP;
                end
                // Counter runs even on stalled cycles so flush length is fixed.
                if (flush_cnt_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // flush_o is a flop mirroring the next state so it lines up with the new PC.
        flush_d = (state_d == FLUSH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_PC;
            flush_cnt_q  <= 3'd0;
            flush_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            flush_cnt_q  <= flush_cnt_d;
            flush_q      <= flush_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign pc           = pc_q;
    assign flush_o      = flush_q;
    assign misaligned_o = misaligned_q;

`ifdef PC_REDIRECT_STATS_EN
    // A branch is counted only when it is not discarded as wrong-path; a
    // simultaneous jump does not add to the counts.
    logic stats_branch_vld;
    logic stats_taken;

    assign stats_branch_vld = (state_q == RUN) && branch_valid;
    assign stats_taken      = branch_result;

    branch_stats_counter u_branch_stats_counter (
        .clk               (clk),
        .reset_n           (reset_n),
        .branch_accept_vld (stats_branch_vld),
        .branch_taken      (stats_taken),
        .branch_count      (branch_count),
        .taken_count       (taken_count)
    );
`else
    assign branch_count = 32'd0;
    assign taken_count  = 32'd0;
`endif

endmodule : pc_redirect_unit

// File: tb/tb_pc_redirect_unit.sv
// Purpose : self-checking bench for pc_redirect_unit against a cycle-level reference model.
// Latency : n/a.
// Backpressure: n/a.
module tb_pc_redirect_unit;

    localparam logic [31:0] T_RESET_PC = 32'h0000_0000;
    localparam int          T_FLUSH    = 2;
`ifdef PC_REDIRECT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall, branch_valid, branch_result, jump_valid;
    logic [31:0] target;
    logic [31:0] pc;
    logic        flush_o, misaligned_o;
    logic [31:0] branch_count, taken_count;

    int compared = 0;
    int mismatched = 0;

    // Reference model: PC value, number of flush cycles still owed, sticky flag, counts.
    logic [31:0] m_pc;
    int          m_flush_left;
    logic        m_mis;
    logic [31:0] m_bc, m_tc;

    always #5 clk = ~clk;

    pc_redirect_unit #(
        .RESET_PC     (T_RESET_PC),
        .FLUSH_CYCLES (T_FLUSH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_valid  (branch_valid),
        .branch_result (branch_result),
        .jump_valid    (jump_valid),
        .target        (target),
        .pc            (pc),
        .flush_o       (flush_o),
        .misaligned_o  (misaligned_o),
        .branch_count  (branch_count),
        .taken_count   (taken_count)
    );

    task automatic model_reset();
        m_pc = T_RESET_PC;
        m_flush_left = 0;
        m_mis = 1'b0;
        m_bc = 32'd0;
        m_tc = 32'd0;
    endtask

    // One clock of the architectural rules, in terms of "flush cycles owed".
    task automatic model_step(input logic s, input logic bv, input logic br,
                              input logic jv, input logic [31:0] tgt);
        if (m_flush_left > 0) begin
            if (!s) m_pc = m_pc + 32'd4;
            m_flush_left = m_flush_left - 1;
        end else begin
            if (bv) begin
                m_bc = m_bc + 32'd1;
                if (br) m_tc = m_tc + 32'd1;
            end
            if ((bv && br) || jv) begin
                m_pc = {tgt[31:1], 1'b0};
                m_flush_left = T_FLUSH;
                if (tgt[1]) m_mis = 1'b1;
            end else if (!s) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // Drive one cycle of inputs, advance clock and model, return #1 after the edge.
    task automatic step(input logic s, input logic bv, input logic br,
                        input logic jv, input logic [31:0] tgt);
        stall = s; branch_valid = bv; branch_result = br; jump_valid = jv; target = tgt;
        @(posedge clk);
        model_step(s, bv, br, jv, tgt);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        stall = 0; branch_valid = 0; branch_result = 0; jump_valid = 0; target = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compared++; if (pc !== T_RESET_PC) begin mismatched++; $display("FAIL reset_pc: got %h want %h", pc, T_RESET_PC); end
        compared++; if (flush_o !== 1'b0) begin mismatched++; $display("FAIL reset_flush: got %b want 0", flush_o); end
        compared++; if (misaligned_o !== 1'b0) begin mismatched++; $display("FAIL reset_mis: got %b want 0", misaligned_o); end
        compared++; if (branch_count !== 32'd0 || taken_count !== 32'd0) begin
            mismatched++; $display("FAIL reset_counts: got %h/%h want 0/0", branch_count, taken_count); end
        reset_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 0, 32'd0);
            compared++; if (pc !== 32'(i * 4)) begin mismatched++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, 32'(i * 4)); end
            compared++; if (flush_o !== 1'b0) begin mismatched++; $display("FAIL seq_flush%0d: got %b want 0", i, flush_o); end
        end
    endtask

    task automatic test_branch_taken();
        // pc is 0x10 here
        step(0, 1, 1, 0, 32'h100);
        compared++; if (pc !== 32'h100 || flush_o !== 1'b1) begin mismatched++; $display("FAIL br_redirect: got pc %h flush %b want 100/1", pc, flush_o); end
        step(0, 0, 0, 0, 32'd0);
        compared++; if (pc !== 32'h104 || flush_o !== 1'b1) begin mismatched++; $display("FAIL br_flush2: got pc %h flush %b want 104/1", pc, flush_o); end
        step(0, 0, 0, 0, 32'd0);
        compared++; if (pc !== 32'h108 || flush_o !== 1'b0) begin mismatched++; $display("FAIL br_done: got pc %h flush %b want 108/0", pc, flush_o); end
        compared++; if (branch_count !== (STATS ? 32'd1 : 32'd0) || taken_count !== (STATS ? 32'd1 : 32'd0)) begin
            mismatched++; $display("FAIL br_counts: got %h/%h want %h/%h", branch_count, taken_count, m_bc & {32{STATS}}, m_tc & {32{STATS}}); end
    endtask

    task automatic test_flush_ignore();
        step(0, 1, 1, 0, 32'h200);
        compared++; if (pc !== 32'h200) begin mismatched++; $display("FAIL fi_redirect: got %h want 200", pc); end
        step(0, 1, 1, 0, 32'h400);  // wrong-path branch inside FLUSH
        compared++; if (pc !== 32'h204) begin mismatched++; $display("FAIL fi_ignore: got %h want 204", pc); end
        step(0, 0, 0, 0, 32'd0);
        compared++; if (pc !== 32'h208 || flush_o !== 1'b0) begin mismatched++; $display("FAIL fi_after: got pc %h flush %b want 208/0", pc, flush_o); end
        compared++; if (branch_count !== (STATS ? 32'd2 : 32'd0) || taken_count !== (STATS ? 32'd2 : 32'd0)) begin
            mismatched++; $display("FAIL fi_counts: got %h/%h want %h/%h", branch_count, taken_count, m_bc & {32{STATS}}, m_tc & {32{STATS}}); end
    endtask

    task automatic test_stall_misaligned();
        // Reach pc = 0x20: jump to 0x18 and let the flush run out.
        step(0, 0, 0, 1, 32'h18);
        step(0, 0, 0, 0, 32'd0);
        step(0, 0, 0, 0, 32'd0);
        compared++; if (pc !== 32'h20 || flush_o !== 1'b0) begin mismatched++; $display("FAIL sm_setup: got pc %h flush %b want 20/0", pc, flush_o); end
        step(1, 0, 0, 1, 32'h303);
        compared++; if (pc !== 32'h302 || flush_o !== 1'b1 || misaligned_o !== 1'b1) begin
            mismatched++; $display("FAIL sm_redirect: got pc %h flush %b mis %b want 302/1/1", pc, flush_o, misaligned_o); end
        step(1, 0, 0, 0, 32'd0);
        compared++; if (pc !== 32'h302 || flush_o !== 1'b1) begin mismatched++; $display("FAIL sm_stall2: got pc %h flush %b want 302/1", pc, flush_o); end
        step(1, 0, 0, 0, 32'd0);
        compared++; if (pc !== 32'h302 || flush_o !== 1'b0 || misaligned_o !== 1'b1) begin
            mismatched++; $display("FAIL sm_stall3: got pc %h flush %b mis %b want 302/0/1", pc, flush_o, misaligned_o); end
        step(0, 0, 0, 0, 32'd0);
        compared++; if (pc !== 32'h306 || misaligned_o !== 1'b1) begin mismatched++; $display("FAIL sm_resume: got pc %h mis %b want 306/1", pc, misaligned_o); end
    endtask

    task automatic test_wrap();
        step(0, 0, 0, 1, 32'hFFFF_FFF0);
        step(0, 0, 0, 0, 32'd0);
        step(0, 0, 0, 0, 32'd0);
        compared++; if (pc !== 32'hFFFF_FFF8 || flush_o !== 1'b0) begin mismatched++; $display("FAIL wrap_setup: got pc %h flush %b want fffffff8/0", pc, flush_o); end
        step(0, 0, 0, 0, 32'd0);
        compared++; if (pc !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_fc: got %h want fffffffc", pc); end
        step(0, 0, 0, 0, 32'd0);
        compared++; if (pc !== 32'h0) begin mismatched++; $display("FAIL wrap_zero: got %h want 0", pc); end
    endtask

    task automatic test_async_reset();
        step(0, 1, 1, 0, 32'h500);
        compared++; if (flush_o !== 1'b1) begin mismatched++; $display("FAIL ar_pre: got flush %b want 1", flush_o); end
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compared++; if (pc !== T_RESET_PC || flush_o !== 1'b0 || misaligned_o !== 1'b0) begin
            mismatched++; $display("FAIL ar_async: got pc %h flush %b mis %b want %h/0/0", pc, flush_o, misaligned_o, T_RESET_PC); end
        compared++; if (branch_count !== 32'd0 || taken_count !== 32'd0) begin
            mismatched++; $display("FAIL ar_counts: got %h/%h want 0/0", branch_count, taken_count); end
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 0, 0, 0, 32'd0);
        compared++; if (pc !== T_RESET_PC + 32'd4 || flush_o !== 1'b0) begin
            mismatched++; $display("FAIL ar_resume: got pc %h flush %b want %h/0", pc, flush_o, T_RESET_PC + 32'd4); end
    endtask

    task automatic test_random();
        logic s, bv, br, jv;
        logic [31:0] tgt;
        for (int i = 0; i < 400; i++) begin
            s   = ($urandom_range(0, 3) == 0);
            bv  = ($urandom_range(0, 2) == 0);
            br  = $urandom_range(0, 1) == 1;
            jv  = ($urandom_range(0, 7) == 0);
            tgt = $urandom();
            if ($urandom_range(0, 3) != 0) tgt[1] = 1'b0;
            step(s, bv, br, jv, tgt);
            compared++; if (pc !== m_pc) begin mismatched++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); end
            compared++; if (flush_o !== (m_flush_left > 0)) begin mismatched++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, flush_o, m_flush_left > 0); end
            compared++; if (misaligned_o !== m_mis) begin mismatched++; $display("FAIL rnd_mis[%0d]: got %b want %b", i, misaligned_o, m_mis); end
            compared++; if (branch_count !== (m_bc & {32{STATS}}) || taken_count !== (m_tc & {32{STATS}})) begin
                mismatched++; $display("FAIL rnd_counts[%0d]: got %h/%h want %h/%h", i, branch_count, taken_count, m_bc & {32{STATS}}, m_tc & {32{STATS}}); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch_taken();
        test_flush_ignore();
        test_stall_misaligned();
        test_wrap();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_pc_redirect_unit
